div_32by16_seq: RTL and testbench

- Sequential unsigned divider: 32-bit dividend by 16-bit divisor, giving a 16-bit quotient and a 16-bit remainder.
- Inverse companion of the 16x16 radix-4 multiplier: it takes a 32-bit product width and recovers the 16-bit operand.
- Radix-4 restoring algorithm: two chained radix-2 restoring steps per clock, so 8 iteration cycles.
- Valid/ready handshakes on input and output. One operation in flight at a time.

---
 rtl/div_pkg.sv | 17 +
 rtl/div_step.sv | 24 ++
 rtl/div_32by16_seq.sv | 150 +++++++++++++++
 tb/tb_div_32by16_seq.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared types and constants for the sequential 32/16 divider.
// Widths, iteration count, FSM states and the saturated quotient.
package div_pkg;

  localparam int DW   = 16;
  localparam int ITER = DW / 2;
  localparam int CW   = $clog2(ITER);

  localparam logic [DW-1:0] QSAT = '1;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_e;

endpackage

// File: rtl/div_step.sv
// One restoring division step: shift in a bit, trial-subtract.
// Two of these in series form one radix-4 iteration.
module div_step
  import div_pkg::*;
(
  input  logic [DW:0]   pr_i,
  input  logic          bit_i,
  input  logic [DW-1:0] dvs_i,
  output logic [DW:0]   pr_o,
  output logic          q_o
);

  logic [DW:0] sh;
  logic [DW:0] diff;

  // shift, subtract, keep difference unless it borrowed
  always_comb begin
    sh   = {pr_i[DW-1:0], bit_i};
    diff = sh - {1'b0, dvs_i};
    q_o  = pr_i[DW] | ~diff[DW];
    pr_o = q_o ? diff : sh;
  end

endmodule

// File: rtl/div_32by16_seq.sv
// Sequential unsigned 32/16 divider, radix-4 restoring.
// Valid/ready in and out, one operation in flight.
module div_32by16_seq
  import div_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2*DW-1:0] dividend,
  input  logic [DW-1:0]   divisor,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [DW-1:0]   quotient,
  output logic [DW-1:0]   remainder,
  output logic            div0,
  output logic            ovf
);

  state_e        state_q, state_d;
  logic [DW:0]   pr_q, pr_d;
  logic [DW-1:0] qsr_q, qsr_d;
  logic [DW-1:0] dvs_q, dvs_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          in_ready_q, in_ready_d;
  logic          out_valid_q, out_valid_d;
  logic [DW-1:0] quotient_q, quotient_d;
  logic [DW-1:0] remainder_q, remainder_d;
  logic          div0_q, div0_d;
  logic          ovf_q, ovf_d;

  logic [DW:0]   pr1, pr2;
  logic          qb1, qb2;
  logic [DW-1:0] qsr_nx;

  div_step u_step1 (
    .pr_i  (pr_q),
    .bit_i (qsr_q[DW-1]),
    .dvs_i (dvs_q),
    .pr_o  (pr1),
    .q_o   (qb1)
  );

  div_step u_step2 (
    .pr_i  (pr1),
    .bit_i (qsr_q[DW-2]),
    .dvs_i (dvs_q),
    .pr_o  (pr2),
    .q_o   (qb2)
  );

  assign qsr_nx = {qsr_q[DW-3:0], qb1, qb2};

  // next-state and datapath control
  always_comb begin
    state_d     = state_q;
    pr_d        = pr_q;
    qsr_d       = qsr_q;
    dvs_d       = dvs_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    div0_d      = div0_q;
    ovf_d       = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          if (divisor == '0) begin
            quotient_d  = QSAT;
            remainder_d = dividend[DW-1:0];
            div0_d      = 1'b1;
            out_valid_d = 1'b1;
            state_d     = DONE;
          end else if (dividend[2*DW-1:DW] >= divisor) begin
            quotient_d  = QSAT;
            remainder_d = dividend[DW-1:0];
            ovf_d       = 1'b1;
            out_valid_d = 1'b1;
            state_d     = DONE;
          end else begin
            pr_d    = {1'b0, dividend[2*DW-1:DW]};
            qsr_d   = dividend[DW-1:0];
            dvs_d   = divisor;
            cnt_d   = '0;
            state_d = CALC;
          end
        end
      end
      CALC: begin
        pr_d  = pr2;
        qsr_d = qsr_nx;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(ITER - 1)) begin
          quotient_d  = qsr_nx;
          remainder_d = pr2[DW-1:0];
          out_valid_d = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          div0_d      = 1'b0;
          ovf_d       = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    in_ready_d = (state_d == IDLE);
  end

  // state and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      pr_q        <= '0;
      qsr_q       <= '0;
      dvs_q       <= '0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      div0_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      pr_q        <= pr_d;
      qsr_q       <= qsr_d;
      dvs_q       <= dvs_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      div0_q      <= div0_d;
      ovf_q       <= ovf_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign quotient  = quotient_q;
  assign remainder = remainder_q;
  assign div0      = div0_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_div_32by16_seq.sv
// Self-checking bench for div_32by16_seq.
// Directed cases, reset mid-op, random round trips.
module tb_div_32by16_seq;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] dividend;
  logic [15:0] divisor;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] quotient;
  logic [15:0] remainder;
  logic        div0;
  logic        ovf;

  typedef struct {
    logic [15:0] q;
    logic [15:0] r;
    logic        d0;
    logic        ov;
  } exp_t;

  exp_t sb[$];
  int   n_chk;
  int   n_fail;

  div_32by16_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dividend  (dividend),
    .divisor   (divisor),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quotient  (quotient),
    .remainder (remainder),
    .div0      (div0),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [31:0] a,
                                 input logic [15:0] b);
    exp_t e;
    logic [31:0] q32;
    logic [31:0] r32;
    e.d0 = 1'b0;
    e.ov = 1'b0;
    if (b == 16'h0) begin
      e.q  = 16'hFFFF;
      e.r  = a[15:0];
      e.d0 = 1'b1;
    end else if (a[31:16] >= b) begin
      e.q  = 16'hFFFF;
      e.r  = a[15:0];
      e.ov = 1'b1;
    end else begin
      q32 = a / {16'h0, b};
      r32 = a % {16'h0, b};
      e.q = q32[15:0];
      e.r = r32[15:0];
    end
    return e;
  endfunction

  // drive one op, pop its expectation, check, optionally hold
  task automatic run_op(input logic [31:0] a,
                        input logic [15:0] b,
                        input int hold);
    exp_t e;
    int   n;
    int   lat;
    int   elat;
    n = 0;
    while (!in_ready && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk("in_ready_before", {31'b0, in_ready}, 32'd1);
    dividend = a;
    divisor  = b;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    dividend = $urandom;
    divisor  = 16'($urandom);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    e    = sb.pop_front();
    elat = (e.d0 || e.ov) ? 0 : 8;
    chk("latency", lat, elat);
    chk("quotient", {16'h0, quotient}, {16'h0, e.q});
    chk("remainder", {16'h0, remainder}, {16'h0, e.r});
    chk("div0", {31'b0, div0}, {31'b0, e.d0});
    chk("ovf", {31'b0, ovf}, {31'b0, e.ov});
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_valid", {31'b0, out_valid}, 32'd1);
      chk("hold_ready", {31'b0, in_ready}, 32'd0);
      chk("hold_q", {16'h0, quotient}, {16'h0, e.q});
      chk("hold_r", {16'h0, remainder}, {16'h0, e.r});
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("post_valid", {31'b0, out_valid}, 32'd0);
    chk("post_ready", {31'b0, in_ready}, 32'd1);
    chk("post_q", {16'h0, quotient}, {16'h0, e.q});
    chk("post_flags", {30'b0, div0, ovf}, 32'd0);
  endtask

  logic [31:0] a;
  logic [15:0] b;
  logic [15:0] x;
  logic [31:0] p;
  logic [15:0] hi;
  int          seen;

  initial begin
    n_chk     = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dividend  = '0;
    divisor   = '0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd0);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_q", {16'h0, quotient}, 32'd0);
    chk("rst_r", {16'h0, remainder}, 32'd0);
    chk("rst_flags", {30'b0, div0, ovf}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_in_ready", {31'b0, in_ready}, 32'd1);

    sb.push_back('{16'hFFFF, 16'h0000, 1'b0, 1'b0});
    run_op(32'hFFFE0001, 16'hFFFF, 0);

    sb.push_back('{16'h000E, 16'h0002, 1'b0, 1'b0});
    run_op(32'h00000064, 16'h0007, 5);

    sb.push_back('{16'hFFFF, 16'h5678, 1'b1, 1'b0});
    run_op(32'h12345678, 16'h0000, 0);
    sb.push_back('{16'h0003, 16'h0000, 1'b0, 1'b0});
    run_op(32'h00000009, 16'h0003, 0);

    sb.push_back('{16'hFFFF, 16'h0000, 1'b0, 1'b1});
    run_op(32'h00010000, 16'h0001, 0);
    sb.push_back('{16'hFFFF, 16'h0000, 1'b0, 1'b0});
    run_op(32'h0000FFFF, 16'h0001, 0);

    sb.push_back('{16'h1234, 16'h0001, 1'b0, 1'b0});
    run_op(32'h12340001 - 32'h12340001 + 32'h00001234 * 32'h0000FFFF + 32'h1, 16'hFFFF, 0);

    dividend = 32'h00001000;
    divisor  = 16'h0003;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_valid", {31'b0, out_valid}, 32'd0);
    chk("mid_ready", {31'b0, in_ready}, 32'd0);
    chk("mid_q", {16'h0, quotient}, 32'd0);
    chk("mid_r", {16'h0, remainder}, 32'd0);
    chk("mid_flags", {30'b0, div0, ovf}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid_rel_ready", {31'b0, in_ready}, 32'd1);
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("no_spurious", seen, 0);

    for (int i = 0; i < 1000; i++) begin
      x = 16'($urandom);
      b = 16'($urandom_range(1, 65535));
      p = {16'h0, x} * {16'h0, b};
      sb.push_back('{x, 16'h0000, 1'b0, 1'b0});
      run_op(p, b, 0);
    end

    for (int i = 0; i < 200; i++) begin
      b  = 16'($urandom_range(1, 65535));
      hi = 16'($urandom_range(0, int'(b) - 1));
      a  = {hi, 16'($urandom)};
      sb.push_back(model(a, b));
      run_op(a, b, 0);
    end

    for (int i = 0; i < 20; i++) begin
      b = 16'($urandom_range(0, 15));
      a = $urandom;
      sb.push_back(model(a, b));
      run_op(a, b, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
